// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register for gapless streaming.
// Optional macro SER_PARITY_EN appends one even-parity bit after every word.
module bit_serializer #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              a_out,
    output logic              a_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
`ifdef SER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              xfer;
    logic              reloadOk;
    logic [DATA_W-1:0] reloadWord;
    logic [DATA_W-1:0] shiftNext;
    logic              curBit;

    assign din_ready = reset & ~hold_full_q;
    assign xfer      = din_valid & din_ready;

    // The held word always goes ahead of anything newly offered on din.
    assign reloadOk   = hold_full_q | xfer;
    assign reloadWord = hold_full_q ? hold_q : din;

    assign shiftNext = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], 1'b0}
                                        : {1'b0, shift_q[DATA_W-1:1]};
    assign curBit    = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer) begin
                    shift_d = din;
                    state_d = SHIFT;
`ifdef SER_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end

            SHIFT: begin
                shift_d = shiftNext;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SER_PARITY_EN
                    // Reload waits for the parity cycle; a word offered now is parked.
                    state_d = PARITY;
                    cnt_d   = '0;
                    if (xfer) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
`else
                    cnt_d = '0;
                    if (reloadOk) begin
                        shift_d     = reloadWord;
                        hold_full_d = 1'b0;
                        state_d     = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else if (xfer) begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
            end

`ifdef SER_PARITY_EN
            PARITY: begin
                cnt_d = '0;
                if (reloadOk) begin
                    shift_d     = reloadWord;
                    parity_d    = ^reloadWord;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                hold_full_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        a_out = 1'b0;
        case (state_q)
            SHIFT:   a_out = curBit;
`ifdef SER_PARITY_EN
            PARITY:  a_out = parity_q;
`endif
            default: a_out = 1'b0;
        endcase
    end

    assign a_valid     = (state_q != IDLE);
    assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign busy        = (state_q != IDLE) | hold_full_q;

endmodule
